// File: rtl/exc_redirect_ctrl.sv
// Exception / ERET redirect sequencer: flush the pipeline, wait for the
// instruction and data buses to drain, then hand fetch a redirect PC.
module exc_redirect_ctrl #(
    parameter int unsigned OUTST_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic        exc_tlb_refill,
    input  logic        eret_req,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_status_bev,
    input  logic        i_issue,
    input  logic        i_done,
    input  logic        d_issue,
    input  logic        d_done,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic        cnt_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_DRAIN,
        S_REDIR
    } state_t;

    localparam logic [OUTST_W-1:0] CNT_MAX = '1;
    localparam logic [OUTST_W-1:0] CNT_ONE = {{(OUTST_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [OUTST_W-1:0] ic_q, ic_d;
    logic [OUTST_W-1:0] dc_q, dc_d;
    logic               err_q, err_d;
    logic [31:0]        pc_q, pc_d;
    logic               ic_bad, dc_bad;

    // Vector selection by cause class and Status.BEV.
    function automatic logic [31:0] exc_vector(input logic bev, input logic refill);
        logic [31:0] v;
        if (bev) v = refill ? 32'hBFC0_0200 : 32'hBFC0_0380;
        else     v = refill ? 32'h8000_0000 : 32'h8000_0180;
        return v;
    endfunction

    // Outstanding-transaction counters: saturate at both ends and flag the error.
    always_comb begin
        ic_d   = ic_q;
        dc_d   = dc_q;
        ic_bad = 1'b0;
        dc_bad = 1'b0;
        if (i_issue && !i_done) begin
            if (ic_q == CNT_MAX) ic_bad = 1'b1;
            else                 ic_d   = ic_q + CNT_ONE;
        end else if (!i_issue && i_done) begin
            if (ic_q == '0)      ic_bad = 1'b1;
            else                 ic_d   = ic_q - CNT_ONE;
        end
        if (d_issue && !d_done) begin
            if (dc_q == CNT_MAX) dc_bad = 1'b1;
            else                 dc_d   = dc_q + CNT_ONE;
        end else if (!d_issue && d_done) begin
            if (dc_q == '0)      dc_bad = 1'b1;
            else                 dc_d   = dc_q - CNT_ONE;
        end
        err_d = err_q | ic_bad | dc_bad;
    end

    // Sequencer next state and target capture; requests outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (exc_req) begin
                    pc_d    = exc_vector(cp0_status_bev, exc_tlb_refill);
                    state_d = S_FLUSH;
                end else if (eret_req) begin
                    pc_d    = cp0_epc;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = S_DRAIN;
            // Uses next-value counts so a done in this cycle ends the drain now.
            S_DRAIN: if (ic_d == '0 && dc_d == '0) state_d = S_REDIR;
            S_REDIR: if (redirect_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters, sticky error and captured target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ic_q    <= '0;
            dc_q    <= '0;
            err_q   <= 1'b0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            ic_q    <= ic_d;
            dc_q    <= dc_d;
            err_q   <= err_d;
            pc_q    <= pc_d;
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        flush          = (state_q == S_FLUSH);
        busy           = (state_q != S_IDLE);
        stall          = (state_q != S_IDLE);
        redirect_valid = (state_q == S_REDIR);
        redirect_pc    = pc_q;
        cnt_err        = err_q;
    end

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Self-checking bench for exc_redirect_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_exc_redirect_ctrl;

    localparam int unsigned OUTST_W = 3;
    localparam int          CMAX    = (1 << OUTST_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exc_req = 1'b0, exc_tlb_refill = 1'b0, eret_req = 1'b0;
    logic [31:0] cp0_epc = '0;
    logic        cp0_status_bev = 1'b0;
    logic        i_issue = 1'b0, i_done = 1'b0, d_issue = 1'b0, d_done = 1'b0;
    logic        redirect_ready = 1'b0;
    logic        flush, stall, redirect_valid, busy, cnt_err;
    logic [31:0] redirect_pc;

    int tests = 0;
    int fails = 0;

    exc_redirect_ctrl #(.OUTST_W(OUTST_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .exc_req        (exc_req),
        .exc_tlb_refill (exc_tlb_refill),
        .eret_req       (eret_req),
        .cp0_epc        (cp0_epc),
        .cp0_status_bev (cp0_status_bev),
        .i_issue        (i_issue),
        .i_done         (i_done),
        .d_issue        (d_issue),
        .d_done         (d_done),
        .redirect_ready (redirect_ready),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .cnt_err        (cnt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: a sequence is "busy" from acceptance until the
    // handshake; age counts cycles since acceptance; the redirect becomes
    // visible once at least two cycles have elapsed and both buses are empty.
    int          m_ic, m_dc, m_age;
    bit          m_err, m_busy, m_valid;
    logic [31:0] m_pc;

    always @(posedge clk or posedge rst) begin
        int nic, ndc;
        if (rst) begin
            m_ic = 0; m_dc = 0; m_age = 0;
            m_err = 0; m_busy = 0; m_valid = 0; m_pc = '0;
        end else begin
            nic = m_ic + int'(i_issue) - int'(i_done);
            ndc = m_dc + int'(d_issue) - int'(d_done);
            if (nic < 0)    begin nic = 0;    m_err = 1; end
            if (nic > CMAX) begin nic = CMAX; m_err = 1; end
            if (ndc < 0)    begin ndc = 0;    m_err = 1; end
            if (ndc > CMAX) begin ndc = CMAX; m_err = 1; end
            m_ic = nic;
            m_dc = ndc;
            if (!m_busy) begin
                if (exc_req || eret_req) begin
                    m_busy = 1; m_age = 0; m_valid = 0;
                    if (exc_req)
                        m_pc = cp0_status_bev ? (exc_tlb_refill ? 32'hBFC0_0200 : 32'hBFC0_0380)
                                              : (exc_tlb_refill ? 32'h8000_0000 : 32'h8000_0180);
                    else
                        m_pc = cp0_epc;
                end
            end else if (m_valid) begin
                if (redirect_ready) begin m_busy = 0; m_valid = 0; end
            end else begin
                m_age = m_age + 1;
                if (m_age >= 2 && nic == 0 && ndc == 0) m_valid = 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("m_flush", {31'd0, flush},          {31'd0, (m_busy && !m_valid && m_age == 0)});
        chk("m_stall", {31'd0, stall},          {31'd0, m_busy});
        chk("m_busy",  {31'd0, busy},           {31'd0, m_busy});
        chk("m_valid", {31'd0, redirect_valid}, {31'd0, m_valid});
        chk("m_pc",    redirect_pc,             m_pc);
        chk("m_err",   {31'd0, cnt_err},        {31'd0, m_err});
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_in();
        exc_req = 0; exc_tlb_refill = 0; eret_req = 0;
        i_issue = 0; i_done = 0; d_issue = 0; d_done = 0;
    endtask

    // Request in cycle k with empty buses: flush k+1, redirect k+3, idle k+4.
    task automatic run_exc(input bit bev, input bit refill, input logic [31:0] exp_pc, input string nm);
        exc_req = 1; exc_tlb_refill = refill; cp0_status_bev = bev; redirect_ready = 1;
        step();
        exc_req = 0; exc_tlb_refill = 0; cp0_status_bev = ~bev;
        chk({nm, "_flush_k1"}, {31'd0, flush}, 32'd1);
        step();
        chk({nm, "_flush_k2"}, {31'd0, flush}, 32'd0);
        chk({nm, "_valid_k2"}, {31'd0, redirect_valid}, 32'd0);
        chk({nm, "_stall_k2"}, {31'd0, stall}, 32'd1);
        step();
        chk({nm, "_valid_k3"}, {31'd0, redirect_valid}, 32'd1);
        chk({nm, "_pc_k3"}, redirect_pc, exp_pc);
        step();
        chk({nm, "_idle_k4"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit seen;
        clear_in();
        rst = 1;
        step(); step();
        chk("rst_busy",  {31'd0, busy},           32'd0);
        chk("rst_pc",    redirect_pc,             32'd0);
        chk("rst_valid", {31'd0, redirect_valid}, 32'd0);
        rst = 0;
        step();

        run_exc(1, 0, 32'hBFC0_0380, "bev1_gen");
        run_exc(0, 1, 32'h8000_0000, "bev0_ref");
        run_exc(0, 0, 32'h8000_0180, "bev0_gen");

        // ERET: EPC captured at the request edge, later changes ignored.
        eret_req = 1; cp0_epc = 32'h8000_1234;
        step();
        eret_req = 0; cp0_epc = 32'hDEAD_BEEF;
        step(); step();
        chk("eret_valid", {31'd0, redirect_valid}, 32'd1);
        chk("eret_pc", redirect_pc, 32'h8000_1234);
        step();
        chk("eret_idle", {31'd0, busy}, 32'd0);

        // Drain: ic=2, dc=1 before the request, retired at k+4..k+8.
        i_issue = 1; d_issue = 1;
        step();
        d_issue = 0;
        step();
        i_issue = 0; exc_req = 1; cp0_status_bev = 1;
        step();
        for (int c = 1; c <= 9; c++) begin
            exc_req = 0;
            if (c <= 8) chk($sformatf("drain_k%0d", c), {30'd0, busy, redirect_valid}, 32'd2);
            else        chk("drain_valid_k9", {30'd0, busy, redirect_valid}, 32'd3);
            i_done  = (c == 4 || c == 6);
            d_done  = (c == 5 || c == 8);
            d_issue = (c == 5);
            step();
        end
        clear_in();
        chk("drain_idle", {31'd0, busy}, 32'd0);

        // Simultaneous exc/eret, fetch back-pressure, extra requests ignored.
        exc_req = 1; eret_req = 1; cp0_status_bev = 0; cp0_epc = 32'h1234_5678;
        redirect_ready = 0;
        step();
        clear_in();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (redirect_valid) seen = 1;
            else step();
        end
        chk("hold_reached", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, redirect_valid}, 32'd1);
            chk("hold_pc", redirect_pc, 32'h8000_0180);
            exc_req = 1; eret_req = 1; exc_tlb_refill = 1; cp0_status_bev = 1;
            step();
        end
        clear_in();
        redirect_ready = 1;
        step();
        chk("hold_idle", {31'd0, busy}, 32'd0);
        chk("hold_pc_kept", redirect_pc, 32'h8000_0180);

        // Underflow on the data counter.
        d_done = 1;
        step();
        d_done = 0;
        chk("uflow_err", {31'd0, cnt_err}, 32'd1);
        run_exc(1, 1, 32'hBFC0_0200, "bev1_ref");
        chk("uflow_sticky", {31'd0, cnt_err}, 32'd1);

        // Reset while draining.
        i_issue = 1;
        step();
        i_issue = 0; exc_req = 1;
        step();
        exc_req = 0;
        step(); step();
        chk("pre_rst_drain", {30'd0, busy, redirect_valid}, 32'd2);
        #2 rst = 1;
        #1;
        chk("rst_mid", {27'd0, flush, stall, redirect_valid, busy, cnt_err}, 32'd0);
        chk("rst_mid_pc", redirect_pc, 32'd0);
        step();
        rst = 0;
        step();
        run_exc(0, 0, 32'h8000_0180, "post_rst");

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            exc_req        = ($urandom_range(0, 9) == 0);
            eret_req       = ($urandom_range(0, 9) == 0);
            exc_tlb_refill = $urandom_range(0, 1);
            cp0_status_bev = $urandom_range(0, 1);
            cp0_epc        = $urandom;
            i_issue        = ($urandom_range(0, 3) == 0);
            i_done         = ($urandom_range(0, 3) == 0);
            d_issue        = ($urandom_range(0, 3) == 0);
            d_done         = ($urandom_range(0, 3) == 0);
            redirect_ready = $urandom_range(0, 1);
            rst            = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0;
        clear_in();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
